pe_array_ctrl: RTL and testbench

Sequencer for the PE_array datapath. It runs a complete CONV1 or CONV2 tile on each start pulse:
- per channel pass: clear the ifmap/weight buffers, stream-load them, align, then fire the PE write enables;
- after the last pass: commit to the psum buffer and drain all 27 psum words as a valid/ready stream.

It sits between the layer scheduler / SRAM fetch unit and PE_array, and replaces hand-sequenced control pulses.

---
 rtl/pe_ctrl_pkg.sv | 23 ++
 rtl/pe_ctrl_addr_gen.sv | 36 +++
 rtl/pe_array_ctrl.sv | 147 ++++++++++++++
 tb/tb_pe_array_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: state encoding, mode codes and geometry defaults shared by the PE array sequencer.
package pe_ctrl_pkg;
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CLR   = 4'd1;
  localparam logic [3:0] S_LDW   = 4'd2;
  localparam logic [3:0] S_LDI   = 4'd3;
  localparam logic [3:0] S_ALIGN = 4'd4;
  localparam logic [3:0] S_PEWEN = 4'd5;
  localparam logic [3:0] S_PSUM  = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic MODE_CONV1 = 1'b0;
  localparam logic MODE_CONV2 = 1'b1;
  localparam int DEF_IFMAP_ROW  = 5;
  localparam int DEF_WEIGHT_ROW = 3;
  localparam int DEF_CONV2_BASE = 36;
  localparam int DEF_PSUM_DEPTH = 27;
  localparam int IFMAP_W     = 8;
  localparam int WEIGHT_W    = 8;
  localparam int PSUM_W      = 16;
  localparam int LD_ADDR_W   = 6;
  localparam int PSUM_ADDR_W = 5;
endpackage

// File: rtl/pe_ctrl_addr_gen.sv
// pe_ctrl_addr_gen: group-aware load address counter; in CONV2 mode the second group starts at BASE.
module pe_ctrl_addr_gen
  import pe_ctrl_pkg::*;
#(
  parameter int AW   = LD_ADDR_W,
  parameter int BASE = DEF_CONV2_BASE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  input  logic          mode,
  input  logic [AW-1:0] row_len,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic [AW-1:0] idx_q, idx_d;
  logic          grp_q, grp_d;
  logic          row_end;
  always_comb begin
    row_end = idx_q == row_len - 1'b1;
    last    = row_end && (mode == MODE_CONV1 || grp_q);
    addr    = grp_q ? idx_q + AW'(BASE) : idx_q;
    idx_d   = clear ? '0 : advance ? (row_end ? '0 : idx_q + 1'b1) : idx_q;
    grp_d   = clear ? 1'b0 : (advance && row_end) ? mode : grp_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      grp_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      grp_q <= grp_d;
    end
  end
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: per-tile sequencer for PE_array (clear, load, align, fire, commit, drain).
// Optional PE_ARRAY_CTRL_PERF_EN adds busy-cycle and stall-cycle counters.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PASS_W     = 4,
  parameter int IFMAP_ROW  = DEF_IFMAP_ROW,
  parameter int WEIGHT_ROW = DEF_WEIGHT_ROW,
  parameter int CONV2_BASE = DEF_CONV2_BASE,
  parameter int PSUM_DEPTH = DEF_PSUM_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [PASS_W-1:0]      num_pass,
  input  logic                   reuse_w,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   i_buff_wen,
  output logic [LD_ADDR_W-1:0]   i_buff_w_addr,
  output logic [IFMAP_W-1:0]     i_buff_w_data,
  output logic                   i_buff_clear,
  output logic                   w_buff_wen,
  output logic [LD_ADDR_W-1:0]   w_buff_w_addr,
  output logic [WEIGHT_W-1:0]    w_buff_w_data,
  output logic                   w_buff_clear,
  output logic                   align_conv1,
  output logic                   align_conv2,
  output logic                   ifmap_pe_wen,
  output logic                   weight_pe_wen,
  output logic                   p_buff_wen,
  output logic [PSUM_ADDR_W-1:0] p_buff_r_addr,
  input  logic [PSUM_W-1:0]      p_buff_r_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PSUM_W-1:0]      out_data,
  output logic                   out_last
`ifdef PE_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_cycles,
  output logic [31:0]            perf_stall
`endif
);
  logic [3:0]             state_q, state_d;
  logic                   mode_q, reuse_q;
  logic [PASS_W-1:0]      npass_q, pass_q;
  logic [PSUM_ADDR_W-1:0] drain_q;
  logic [LD_ADDR_W-1:0]   ld_addr;
  logic                   ld_last, ld_st, ld_hs, out_hs, last_pass, accept;
  assign accept    = state_q == S_IDLE && start;
  assign ld_st     = state_q == S_LDW || state_q == S_LDI;
  assign ld_hs     = ld_st && in_valid;
  assign out_hs    = state_q == S_DRAIN && out_ready;
  assign last_pass = npass_q == '0 ? pass_q == '0 : pass_q == npass_q - 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLR;
      S_CLR:   state_d = reuse_q ? S_LDI : S_LDW;
      S_LDW:   if (ld_hs && ld_last) state_d = S_LDI;
      S_LDI:   if (ld_hs && ld_last) state_d = S_ALIGN;
      S_ALIGN: state_d = S_PEWEN;
      S_PEWEN: state_d = last_pass ? S_PSUM : S_CLR;
      S_PSUM:  state_d = S_DRAIN;
      S_DRAIN: if (out_hs && out_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // Any state change restarts the load address, so each LDW/LDI begins at 0.
  pe_ctrl_addr_gen #(.AW(LD_ADDR_W), .BASE(CONV2_BASE)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != state_d),
    .advance (ld_hs),
    .mode    (mode_q),
    .row_len (state_q == S_LDW ? LD_ADDR_W'(WEIGHT_ROW) : LD_ADDR_W'(IFMAP_ROW)),
    .addr    (ld_addr),
    .last    (ld_last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_CONV1;
      reuse_q <= 1'b0;
      npass_q <= '0;
      pass_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= mode;
        reuse_q <= reuse_w;
        npass_q <= num_pass;
        pass_q  <= '0;
      end else if (state_q == S_PEWEN) begin
        pass_q  <= pass_q + 1'b1;
      end
      if (out_hs) drain_q <= out_last ? '0 : drain_q + 1'b1;
    end
  end
  always_comb begin
    busy          = state_q != S_IDLE;
    done          = state_q == S_DONE;
    in_ready      = ld_st;
    i_buff_wen    = state_q == S_LDI && in_valid;
    i_buff_w_addr = state_q == S_LDI ? ld_addr : '0;
    i_buff_w_data = state_q == S_LDI ? in_data[IFMAP_W-1:0] : '0;
    i_buff_clear  = state_q == S_CLR;
    w_buff_wen    = state_q == S_LDW && in_valid;
    w_buff_w_addr = state_q == S_LDW ? ld_addr : '0;
    w_buff_w_data = state_q == S_LDW ? in_data[WEIGHT_W-1:0] : '0;
    w_buff_clear  = state_q == S_CLR && !reuse_q;
    align_conv1   = state_q == S_ALIGN && mode_q == MODE_CONV1;
    align_conv2   = state_q == S_ALIGN && mode_q == MODE_CONV2;
    ifmap_pe_wen  = state_q == S_PEWEN;
    weight_pe_wen = state_q == S_PEWEN && !reuse_q;
    p_buff_wen    = state_q == S_PSUM;
    p_buff_r_addr = drain_q;
    out_valid     = state_q == S_DRAIN;
    out_data      = state_q == S_DRAIN ? p_buff_r_data : '0;
    out_last      = state_q == S_DRAIN && drain_q == PSUM_ADDR_W'(PSUM_DEPTH - 1);
  end
`ifdef PE_ARRAY_CTRL_PERF_EN
  logic [31:0] cyc_q, stall_q;
  logic        stall;
  assign stall = (ld_st && !in_valid) || (state_q == S_DRAIN && !out_ready);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (accept) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      if (busy && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (stall && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end
  assign perf_cycles = cyc_q;
  assign perf_stall  = stall_q;
`endif
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: randomized scenarios checked against a stream/address model of the sequencer.
module tb_pe_array_ctrl;
  typedef struct packed {logic [5:0] addr; logic [7:0] data;} wr_t;
  typedef struct packed {logic [4:0] addr; logic [15:0] data; logic last;} beat_t;
  localparam int BUDGET = 3000;
  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, mode = 1'b0, reuse_w = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] num_pass = '0;
  logic [7:0] in_data = '0;
  logic busy, done, in_ready, i_buff_wen, i_buff_clear, w_buff_wen, w_buff_clear;
  logic [5:0] i_buff_w_addr, w_buff_w_addr;
  logic [7:0] i_buff_w_data, w_buff_w_data;
  logic align_conv1, align_conv2, ifmap_pe_wen, weight_pe_wen, p_buff_wen, out_valid, out_last;
  logic [4:0] p_buff_r_addr;
  logic [15:0] p_buff_r_data, out_data;
  logic [15:0] psum_mem [27];
  logic [62:0] outs;
`ifdef PE_ARRAY_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif
  int checks = 0, failures = 0;
  logic [7:0] stream[$];
  wr_t exp_w[$], exp_i[$], w_log[$], i_log[$];
  beat_t beats[$];
  int stall_addrs[$];
  int sptr, n_hs, bad_wen, n_align1, n_align2, n_ifpe, n_wpe, n_pbw, n_wclr, n_iclr, n_done;
  int c_align, c_pewen, c_pbw, c_drain0, c_done, pbw_ifpe;

  always #5 clk = ~clk;
  assign p_buff_r_data = p_buff_r_addr < 5'd27 ? psum_mem[p_buff_r_addr] : 16'h0;
  assign outs = {busy, done, in_ready, i_buff_wen, i_buff_w_addr, i_buff_w_data, i_buff_clear,
                 w_buff_wen, w_buff_w_addr, w_buff_w_data, w_buff_clear, align_conv1, align_conv2,
                 ifmap_pe_wen, weight_pe_wen, p_buff_wen, p_buff_r_addr, out_valid, out_data, out_last};

  pe_array_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_pass(num_pass), .reuse_w(reuse_w),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .i_buff_wen(i_buff_wen), .i_buff_w_addr(i_buff_w_addr), .i_buff_w_data(i_buff_w_data),
    .i_buff_clear(i_buff_clear), .w_buff_wen(w_buff_wen), .w_buff_w_addr(w_buff_w_addr),
    .w_buff_w_data(w_buff_w_data), .w_buff_clear(w_buff_clear), .align_conv1(align_conv1),
    .align_conv2(align_conv2), .ifmap_pe_wen(ifmap_pe_wen), .weight_pe_wen(weight_pe_wen),
    .p_buff_wen(p_buff_wen), .p_buff_r_addr(p_buff_r_addr), .p_buff_r_data(p_buff_r_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef PE_ARRAY_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  // Reference: words are consumed in order, weights then ifmap per pass, groups at 0 and 36.
  task automatic model_tile(input bit m, input int np, input bit ru, input bit keep);
    int eff, g, p;
    eff = np == 0 ? 1 : np;
    g = m ? 2 : 1;
    p = 0;
    if (!keep) begin
      stream.delete();
      repeat (eff * ((ru ? 0 : 3 * g) + 5 * g)) stream.push_back(8'($urandom));
    end
    exp_w.delete();
    exp_i.delete();
    for (int ps = 0; ps < eff; ps++) begin
      if (!ru)
        for (int gi = 0; gi < g; gi++)
          for (int j = 0; j < 3; j++) begin exp_w.push_back({6'(gi * 36 + j), stream[p]}); p++; end
      for (int gi = 0; gi < g; gi++)
        for (int j = 0; j < 5; j++) begin exp_i.push_back({6'(gi * 36 + j), stream[p]}); p++; end
    end
    foreach (psum_mem[i]) psum_mem[i] = 16'($urandom);
  endtask

  task automatic run_tile(input bit m, input int np, input bit ru, input int gap,
                          input bit stall5, input bit rnd_rdy, input bit xstart, input bit abort);
    int stalls;
    w_log.delete(); i_log.delete(); beats.delete(); stall_addrs.delete();
    {sptr, n_hs, bad_wen, n_align1, n_align2, n_ifpe, n_wpe, n_pbw, n_wclr, n_iclr, n_done} = '0;
    {c_align, c_pewen, c_pbw, c_drain0, c_done, pbw_ifpe} = '0;
    stalls = 0;
    @(posedge clk); #1;
    mode = m; num_pass = 4'(np); reuse_w = ru; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; num_pass = 4'($urandom); reuse_w = ~ru;
    for (int k = 1; k <= BUDGET; k++) begin
      in_valid = gap == 0 ? 1'b1 : gap == 1 ? k[0] : ($urandom % 3 != 0);
      in_data = sptr < stream.size() ? stream[sptr] : 8'($urandom);
      out_ready = (stall5 && beats.size() == 5 && stalls < 3) ? 1'b0 : rnd_rdy ? 1'($urandom) : 1'b1;
      start = xstart && beats.size() == 3;
      @(negedge clk);
      if (w_buff_wen) begin w_log.push_back({w_buff_w_addr, w_buff_w_data}); if (!in_valid) bad_wen++; end
      if (i_buff_wen) begin i_log.push_back({i_buff_w_addr, i_buff_w_data}); if (!in_valid) bad_wen++; end
      if (in_valid && in_ready) begin sptr++; n_hs++; end
      if (align_conv1) begin n_align1++; c_align = k; end
      if (align_conv2) begin n_align2++; c_align = k; end
      if (ifmap_pe_wen) begin n_ifpe++; c_pewen = k; end
      if (weight_pe_wen) n_wpe++;
      if (p_buff_wen) begin n_pbw++; c_pbw = k; pbw_ifpe = n_ifpe; end
      if (w_buff_clear) n_wclr++;
      if (i_buff_clear) n_iclr++;
      if (out_valid) begin
        if (c_drain0 == 0) c_drain0 = k;
        if (stall5 && beats.size() == 5 && !out_ready) begin stall_addrs.push_back(int'(p_buff_r_addr)); stalls++; end
        if (out_ready) beats.push_back({p_buff_r_addr, out_data, out_last});
      end
      if (abort && i_buff_w_addr == 6'd2) begin rst = 1'b0; return; end
      if (done) begin n_done++; c_done = k; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (c_done == 0) begin failures++; $display("FAIL timeout: no done within %0d cycles", BUDGET); end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_conv1_latency();
    stream = '{8'hFF, 8'd9, 8'hF9, 8'd1, 8'd2, 8'd7, 8'd1, 8'd6};
    model_tile(0, 1, 0, 1);
    run_tile(0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (w_log !== exp_w) begin failures++; $display("FAIL c1_wwrites: got %0d entries want %0d", w_log.size(), exp_w.size()); end
    checks++; if (i_log !== exp_i) begin failures++; $display("FAIL c1_iwrites: got %0d entries want %0d", i_log.size(), exp_i.size()); end
    checks++; if (c_align !== 10 || n_align1 !== 1) begin failures++; $display("FAIL c1_align: cycle %0d count %0d want 10/1", c_align, n_align1); end
    checks++; if (c_pewen !== 11 || n_wpe !== 1) begin failures++; $display("FAIL c1_pewen: cycle %0d wpe %0d want 11/1", c_pewen, n_wpe); end
    checks++; if (c_pbw !== 12) begin failures++; $display("FAIL c1_pbw: cycle %0d want 12", c_pbw); end
    checks++; if (c_drain0 !== 13) begin failures++; $display("FAIL c1_drain_start: cycle %0d want 13", c_drain0); end
    checks++; if (c_done !== 40) begin failures++; $display("FAIL c1_done: cycle %0d want 40", c_done); end
    checks++; if (beats.size() !== 27) begin failures++; $display("FAIL c1_beats: got %0d want 27", beats.size()); end
    for (int j = 0; j < beats.size(); j++) begin
      checks++;
      if (beats[j] !== {5'(j), psum_mem[j], j == 26}) begin
        failures++; $display("FAIL c1_beat%0d: got %h want %h", j, beats[j], {5'(j), psum_mem[j], j == 26});
      end
    end
`ifdef PE_ARRAY_CTRL_PERF_EN
    @(negedge clk);
    checks++; if (perf_cycles !== 32'd40 || perf_stall !== 32'd0) begin
      failures++; $display("FAIL perf: cycles=%0d stall=%0d want 40/0", perf_cycles, perf_stall); end
`endif
  endtask

  task automatic test_conv2_multipass();
    model_tile(1, 3, 0, 0);
    run_tile(1, 3, 0, 2, 0, 1, 0, 0);
    checks++; if (w_log !== exp_w) begin failures++; $display("FAIL c2_wwrites: got %0d entries want %0d", w_log.size(), exp_w.size()); end
    checks++; if (i_log !== exp_i) begin failures++; $display("FAIL c2_iwrites: got %0d entries want %0d", i_log.size(), exp_i.size()); end
    checks++; if (n_align2 !== 3 || n_align1 !== 0) begin failures++; $display("FAIL c2_align: a2=%0d a1=%0d want 3/0", n_align2, n_align1); end
    checks++; if (n_pbw !== 1 || pbw_ifpe !== 3 || c_pbw !== c_pewen + 1) begin
      failures++; $display("FAIL c2_pbw: n=%0d after_pewen=%0d cyc=%0d want 1/3/%0d", n_pbw, pbw_ifpe, c_pbw, c_pewen + 1); end
    checks++; if (n_wclr !== 3 || n_iclr !== 3 || n_wpe !== 3) begin
      failures++; $display("FAIL c2_clr: wclr=%0d iclr=%0d wpe=%0d want 3/3/3", n_wclr, n_iclr, n_wpe); end
    checks++; if (bad_wen !== 0) begin failures++; $display("FAIL c2_wen_no_valid: got %0d want 0", bad_wen); end
    for (int j = 0; j < 27; j++) begin
      checks++;
      if (beats[j] !== {5'(j), psum_mem[j], j == 26}) begin
        failures++; $display("FAIL c2_beat%0d: got %h want %h", j, beats[j], {5'(j), psum_mem[j], j == 26});
      end
    end
  endtask

  task automatic test_reuse_weights();
    model_tile(0, 4, 1, 0);
    run_tile(0, 4, 1, 2, 0, 0, 0, 0);
    checks++; if (n_wclr !== 0 || w_log.size() !== 0 || n_wpe !== 0) begin
      failures++; $display("FAIL reuse_weights: wclr=%0d wwr=%0d wpe=%0d want 0/0/0", n_wclr, w_log.size(), n_wpe); end
    checks++; if (n_ifpe !== 4) begin failures++; $display("FAIL reuse_ifpe: got %0d want 4", n_ifpe); end
    checks++; if (n_hs !== 20) begin failures++; $display("FAIL reuse_handshakes: got %0d want 20", n_hs); end
    checks++; if (i_log !== exp_i) begin failures++; $display("FAIL reuse_iwrites: got %0d entries want %0d", i_log.size(), exp_i.size()); end
  endtask

  task automatic test_backpressure();
    model_tile(0, 1, 0, 0);
    run_tile(0, 1, 0, 1, 1, 0, 0, 0);
    checks++; if (w_log !== exp_w || i_log !== exp_i) begin failures++; $display("FAIL bp_writes: w=%0d i=%0d want %0d/%0d", w_log.size(), i_log.size(), exp_w.size(), exp_i.size()); end
    checks++; if (bad_wen !== 0) begin failures++; $display("FAIL bp_wen_no_valid: got %0d want 0", bad_wen); end
    checks++; if (stall_addrs.size() !== 3) begin failures++; $display("FAIL bp_stall_cycles: got %0d want 3", stall_addrs.size()); end
    foreach (stall_addrs[j]) begin
      checks++; if (stall_addrs[j] !== 5) begin failures++; $display("FAIL bp_hold%0d: addr %0d want 5", j, stall_addrs[j]); end
    end
    checks++; if (beats.size() !== 27) begin failures++; $display("FAIL bp_beats: got %0d want 27", beats.size()); end
    for (int j = 0; j < beats.size(); j++) begin
      checks++;
      if (beats[j] !== {5'(j), psum_mem[j], j == 26}) begin
        failures++; $display("FAIL bp_beat%0d: got %h want %h", j, beats[j], {5'(j), psum_mem[j], j == 26});
      end
    end
  endtask

  task automatic test_start_in_drain();
    int late_busy;
    model_tile(0, 0, 0, 0);
    run_tile(0, 0, 0, 0, 0, 0, 1, 0);
    late_busy = 0;
    repeat (5) @(negedge clk) if (busy) late_busy++;
    checks++; if (n_ifpe !== 1 || n_done !== 1) begin failures++; $display("FAIL np0_passes: pewen=%0d done=%0d want 1/1", n_ifpe, n_done); end
    checks++; if (c_done !== 40) begin failures++; $display("FAIL np0_done: cycle %0d want 40", c_done); end
    checks++; if (late_busy !== 0) begin failures++; $display("FAIL extra_start: busy cycles after done %0d want 0", late_busy); end
  endtask

  task automatic test_async_abort();
    model_tile(0, 1, 0, 0);
    run_tile(0, 1, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (outs !== '0) begin failures++; $display("FAIL abort_outputs: got %h want 0", outs); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle: busy=%b want 0", busy); end
    model_tile(0, 1, 0, 0);
    run_tile(0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (n_iclr !== 1 || i_log !== exp_i || w_log !== exp_w) begin
      failures++; $display("FAIL abort_rerun: iclr=%0d i=%0d w=%0d want 1/5/3", n_iclr, i_log.size(), w_log.size()); end
    checks++; if (c_done !== 40) begin failures++; $display("FAIL abort_rerun_done: cycle %0d want 40", c_done); end
  endtask

  initial begin
    test_reset();
    test_conv1_latency();
    test_conv2_multipass();
    test_reuse_weights();
    test_backpressure();
    test_start_in_drain();
    test_async_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
